pc_seq_ctrl: RTL and testbench

//  Owns the IF-stage program counter of the 5-stage pipeline and sequences next-PC selection.

---
 rtl/pc_seq_ctrl_pkg.sv | 20 ++
 rtl/npc_target_calc.sv | 28 ++
 rtl/pc_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// rtl/pc_seq_ctrl_pkg.sv - next-PC opcodes, sequencer states and redirect decode shared by pc_seq_ctrl
package pc_seq_ctrl_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    typedef enum logic [1:0] {
        PCC_ST_BOOT  = 2'd0,
        PCC_ST_RUN   = 2'd1,
        PCC_ST_WAIT  = 2'd2,
        PCC_ST_FLUSH = 2'd3
    } pcc_state_e;

    function automatic logic is_redirect(input logic valid, input logic [2:0] op, input logic taken);
        return valid & (((op == NPC_BRANCH) & taken) | (op == NPC_JUMP) | (op == NPC_JALR));
    endfunction

endpackage

// File: rtl/npc_target_calc.sv
// rtl/npc_target_calc.sv - EX redirect target adder/mux with alignment check
// PC_ALIGN_TRAP_EN: misaligned targets go to TRAP_PC and raise misalign; otherwise low bits are cleared.
module npc_target_calc
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_PC = 32'h0000_0100
) (
    input  logic [2:0]  op,
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] aluout,
    output logic [31:0] target,
    output logic        misalign
);

    logic [31:0] raw;

    always_comb begin
        raw = (op == NPC_JALR) ? (aluout & ~32'h1) : (ex_pc + imm);
`ifdef PC_ALIGN_TRAP_EN
        misalign = (raw[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        target = misalign ? TRAP_PC : (raw & ~32'h3);
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - IF-stage PC owner: sequential fetch, EX redirects, stalls, imem waits, flushes
// Optional PC_ALIGN_TRAP_EN enables the misaligned-target trap in npc_target_calc.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC          = 32'h0000_0100,
    parameter int          REDIRECT_BUBBLES = 1,
    parameter int          CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             ex_valid_i,
    input  logic [2:0]       ex_npc_op_i,
    input  logic             br_taken_i,
    input  logic [31:0]      ex_pc_i,
    input  logic [31:0]      ex_imm_i,
    input  logic [31:0]      ex_aluout_i,
    input  logic             imem_ready_i,
    output logic [31:0]      pc_o,
    output logic             fetch_valid_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic [CNT_W-1:0] redir_cnt_o,
    output logic             misalign_o
);

    localparam logic [1:0] BUBBLES = 2'(REDIRECT_BUBBLES);
    localparam pcc_state_e AFTER_REDIR = (REDIRECT_BUBBLES == 0) ? PCC_ST_RUN : PCC_ST_FLUSH;

    pcc_state_e       st_q, st_d;
    logic [31:0]      pc_q, pc_d, pend_pc_q, pend_pc_d, tgt;
    logic             pend_q, pend_d, pend_mis_q, pend_mis_d, tgt_mis;
    logic [1:0]       bub_q, bub_d;
    logic [CNT_W-1:0] cnt_q;
    logic             redirect, apply, apply_mis, drop;

    npc_target_calc #(.TRAP_PC(TRAP_PC)) u_target (
        .op       (ex_npc_op_i),
        .ex_pc    (ex_pc_i),
        .imm      (ex_imm_i),
        .aluout   (ex_aluout_i),
        .target   (tgt),
        .misalign (tgt_mis)
    );

    always_comb begin
        redirect      = is_redirect(ex_valid_i, ex_npc_op_i, br_taken_i);
        st_d          = st_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        pend_d        = pend_q;
        pend_mis_d    = pend_mis_q;
        bub_d         = bub_q;
        apply         = 1'b0;
        apply_mis     = 1'b0;
        drop          = 1'b0;
        fetch_valid_o = 1'b0;
        case (st_q)
            PCC_ST_BOOT: st_d = PCC_ST_RUN;
            PCC_ST_RUN: begin
                fetch_valid_o = 1'b1;
                if (redirect && imem_ready_i) begin
                    pc_d      = tgt;
                    apply     = 1'b1;
                    apply_mis = tgt_mis;
                    bub_d     = BUBBLES;
                    st_d      = AFTER_REDIR;
                end else if (redirect) begin
                    pend_pc_d  = tgt;
                    pend_mis_d = tgt_mis;
                    pend_d     = 1'b1;
                    st_d       = PCC_ST_WAIT;
                end else if (!imem_ready_i) begin
                    st_d = PCC_ST_WAIT;
                end else if (!stall_i) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            PCC_ST_WAIT: begin
                fetch_valid_o = 1'b1;
                // The outstanding fetch must complete; a newer redirect replaces the older one.
                if (redirect) begin
                    pend_pc_d  = tgt;
                    pend_mis_d = tgt_mis;
                    pend_d     = 1'b1;
                end
                if (imem_ready_i) begin
                    if (pend_d) begin
                        pc_d      = pend_pc_d;
                        apply     = 1'b1;
                        apply_mis = pend_mis_d;
                        drop      = 1'b1;
                        pend_d    = 1'b0;
                        bub_d     = BUBBLES;
                        st_d      = AFTER_REDIR;
                    end else begin
                        if (!stall_i) pc_d = pc_q + 32'd4;
                        st_d = PCC_ST_RUN;
                    end
                end
            end
            PCC_ST_FLUSH: begin
                if (redirect) begin
                    pc_d      = tgt;
                    apply     = 1'b1;
                    apply_mis = tgt_mis;
                    bub_d     = BUBBLES;
                end else begin
                    bub_d = bub_q - 2'd1;
                    if (bub_q == 2'd1) st_d = PCC_ST_RUN;
                end
            end
            default: st_d = PCC_ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= PCC_ST_BOOT;
            pc_q       <= RESET_PC;
            pend_pc_q  <= 32'd0;
            pend_q     <= 1'b0;
            pend_mis_q <= 1'b0;
            bub_q      <= 2'd0;
            cnt_q      <= '0;
        end else begin
            st_q       <= st_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_q     <= pend_d;
            pend_mis_q <= pend_mis_d;
            bub_q      <= bub_d;
            if (apply && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign pc_o         = pc_q;
    assign flush_idex_o = (st_q != PCC_ST_BOOT) & redirect;
    assign flush_ifid_o = (st_q != PCC_ST_BOOT) & (redirect | drop);
    assign redir_cnt_o  = cnt_q;
    assign misalign_o   = apply_mis;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - directed bench for pc_seq_ctrl with per-cycle reference model
module tb_pc_seq_ctrl;
    import pc_seq_ctrl_pkg::*;

    localparam int          BUB  = 1;
    localparam int          CW   = 2;
    localparam int          SAT  = (1 << CW) - 1;
    localparam logic [31:0] TRAP = 32'h0000_0100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0, ex_valid = 1'b0, taken = 1'b0, ready = 1'b1;
    logic [2:0]    op = NPC_PLUS4;
    logic [31:0]   ex_pc = 32'd0, imm = 32'd0, alu = 32'd0;
    logic [31:0]   pc;
    logic          fv, fl_ifid, fl_idex, mis;
    logic [CW-1:0] rc;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    pc_seq_ctrl #(
        .RESET_PC(32'h0), .TRAP_PC(TRAP), .REDIRECT_BUBBLES(BUB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .ex_valid_i(ex_valid), .ex_npc_op_i(op),
        .br_taken_i(taken), .ex_pc_i(ex_pc), .ex_imm_i(imm), .ex_aluout_i(alu),
        .imem_ready_i(ready), .pc_o(pc), .fetch_valid_o(fv), .flush_ifid_o(fl_ifid),
        .flush_idex_o(fl_idex), .redir_cnt_o(rc), .misalign_o(mis)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural view of fetch (pc, boot flag, waiting, pending target, bubbles left)
    logic [31:0] m_pc, m_pend_pc;
    bit          m_boot, m_wait, m_pend, m_pend_mis;
    int          m_bub, m_cnt;

    function automatic logic [32:0] model_target(input logic [2:0] o, input logic [31:0] p,
                                                 input logic [31:0] i, input logic [31:0] a);
        logic [31:0] raw;
        raw = (o == NPC_JALR) ? (a & ~32'h1) : (p + i);
`ifdef PC_ALIGN_TRAP_EN
        if (raw % 4 != 0) return {1'b1, TRAP};
`endif
        return {1'b0, raw & ~32'h3};
    endfunction

    function automatic bit redir_now();
        return ex_valid && ((op == NPC_BRANCH && taken) || op == NPC_JUMP || op == NPC_JALR);
    endfunction

    function automatic bit applies_now();
        if (m_boot) return 1'b0;
        if (m_bub > 0) return redir_now();
        if (m_wait) return ready && (m_pend || redir_now());
        return redir_now() && ready;
    endfunction

    function automatic logic [32:0] applied_target();
        if (m_wait && !redir_now()) return {m_pend_mis, m_pend_pc};
        return model_target(op, ex_pc, imm, alu);
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [31:0] n_pc;
        logic [32:0] t, nt;
        bit          r, ap;
        if (rst) begin
            m_pc <= 32'h0; m_boot <= 1'b1; m_wait <= 1'b0; m_pend <= 1'b0;
            m_pend_pc <= 32'h0; m_pend_mis <= 1'b0; m_bub <= 0; m_cnt <= 0;
        end else begin
            r  = redir_now();
            ap = applies_now();
            t  = applied_target();
            nt = model_target(op, ex_pc, imm, alu);
            n_pc = m_pc;
            if (m_boot) begin
                m_boot <= 1'b0;
            end else if (ap) begin
                n_pc = t[31:0];
                m_bub <= BUB; m_wait <= 1'b0; m_pend <= 1'b0; m_cnt <= m_cnt + 1;
            end else if (m_bub > 0) begin
                m_bub <= m_bub - 1;
            end else if (r) begin
                m_wait <= 1'b1; m_pend <= 1'b1; m_pend_pc <= nt[31:0]; m_pend_mis <= nt[32];
            end else if (m_wait) begin
                if (ready) begin
                    m_wait <= 1'b0;
                    if (!stall) n_pc = m_pc + 32'd4;
                end
            end else if (!ready) begin
                m_wait <= 1'b1;
            end else if (!stall) begin
                n_pc = m_pc + 32'd4;
            end
            m_pc <= n_pc;
        end
    end

    always @(negedge clk) begin
        logic [32:0] t;
        bit          r, ap;
        if (!rst) begin
            r  = redir_now();
            ap = applies_now();
            t  = applied_target();
            chk("m_pc", pc, m_pc);
            chk("m_fetch_valid", fv, !m_boot && m_bub == 0);
            chk("m_flush_idex", fl_idex, !m_boot && r);
            chk("m_flush_ifid", fl_ifid, !m_boot && (r || (m_wait && ready && m_pend)));
            chk("m_misalign", mis, ap && t[32]);
            chk("m_redir_cnt", rc, (m_cnt > SAT) ? SAT : m_cnt);
        end
    end

    task automatic cyc(input logic s, input logic v, input logic [2:0] o, input logic tk,
                       input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                       input logic rdy);
        @(posedge clk);
        #2;
        stall = s; ex_valid = v; op = o; taken = tk; ex_pc = p; imm = i; alu = a; ready = rdy;
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 1'b0, NPC_PLUS4, 1'b0, 32'h0, 32'h0, 32'h0, rdy);
    endtask

    logic [31:0] exp_j2;

    initial begin
`ifdef PC_ALIGN_TRAP_EN
        exp_j2 = 32'h100;
`else
        exp_j2 = 32'h84;
`endif
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", fv, 0);
        chk("rst_cnt", rc, 0);
        chk("rst_flush", {fl_ifid, fl_idex}, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("boot_fv", fv, 0);

        idle(1);                                  chk("seq0", pc, 32'h0); chk("seq0_fv", fv, 1);
        cyc(0, 1, NPC_BRANCH, 0, 0, 32'h40, 0, 1); chk("seq4", pc, 32'h4); chk("nt_flush", fl_idex, 0);
        cyc(0, 0, NPC_JUMP, 0, 0, 32'h40, 0, 1);  chk("seq8", pc, 32'h8); chk("inv_flush", fl_ifid, 0);
        idle(1);                                  chk("seqC", pc, 32'hC);

        cyc(0, 1, NPC_BRANCH, 1, 32'h10, 32'h20, 0, 1);
        chk("br_ifid", fl_ifid, 1); chk("br_idex", fl_idex, 1);
        idle(1); chk("br_pc", pc, 32'h30); chk("br_bubble", fv, 0); chk("br_cnt", rc, 1);
        idle(1); chk("br_resume", fv, 1);

        cyc(0, 1, NPC_JALR, 0, 0, 0, 32'h85, 1);
        idle(1); chk("jalr_pc", pc, 32'h84); chk("jalr_cnt", rc, 2);
        idle(1);
        cyc(0, 1, NPC_JALR, 0, 0, 0, 32'h86, 1);
`ifdef PC_ALIGN_TRAP_EN
        chk("jalr2_mis", mis, 1);
`else
        chk("jalr2_mis", mis, 0);
`endif
        idle(1); chk("jalr2_pc", pc, exp_j2); chk("jalr2_mis_gone", mis, 0);
        idle(1);

        idle(0);                                  chk("wait_pc0", pc, exp_j2 + 4);
        cyc(0, 1, NPC_JUMP, 0, 32'h100, 32'h100, 0, 0); chk("wait_pc1", pc, exp_j2 + 4);
        idle(0);                                  chk("wait_pc2", pc, exp_j2 + 4); chk("wait_fv", fv, 1);
        idle(1);                                  chk("wait_drop", fl_ifid, 1); chk("wait_idex", fl_idex, 0);
        idle(1); chk("jmp_pc", pc, 32'h200); chk("cnt_sat", rc, 3);
        idle(1);

        cyc(1, 1, NPC_BRANCH, 1, 32'h40, 32'h10, 0, 1); chk("stall_br_flush", fl_idex, 1);
        cyc(1, 0, NPC_PLUS4, 0, 0, 0, 0, 1);      chk("stall_br_pc", pc, 32'h50);
        cyc(1, 0, NPC_PLUS4, 0, 0, 0, 0, 1);      chk("stall_pc0", pc, 32'h50);
        cyc(1, 0, NPC_PLUS4, 0, 0, 0, 0, 1);      chk("stall_pc1", pc, 32'h50);
        idle(1);                                  chk("stall_pc2", pc, 32'h50);
        idle(1);                                  chk("stall_rel", pc, 32'h54);

        cyc(0, 1, NPC_JUMP, 0, 32'h54, 32'h8, 0, 1);
        idle(1); chk("flush_pc", pc, 32'h5C); chk("flush_fv", fv, 0);
        rst = 1'b1;
        #1;
        chk("mrst_pc", pc, 32'h0); chk("mrst_cnt", rc, 0); chk("mrst_fv", fv, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        idle(1); chk("post_rst_pc0", pc, 32'h0);
        idle(1); chk("post_rst_pc4", pc, 32'h4);
        idle(1);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
